hazard_scoreboard: RTL and testbench

- Parametrised register-index tracker and hazard unit for the pipelined core. Generalises the fixed three-stage destination-index pipeline and its comparators to STAGES post-decode stages and REG_BITS-wide indices.
- Each in-flight entry carries a per-instruction result latency, so a forwarding source is only selected once its result actually exists.
- Emits decode-stage forward selects and a decode stall, and also tracks a multicycle multiply/divide unit.
- Sits beside the datapath and drives the decode operand muxes and the stall network.

---
 rtl/hazard_scoreboard.sv | 142 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Destination-index tracker and hazard unit for the pipelined core. Keeps one
//   {valid, dest, lat} entry per post-decode stage (stage 1 = E ... STAGES = W),
//   produces decode operand forward selects and a decode stall, and tracks the
//   busy window of the multicycle multiply/divide unit.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   issue_*_D           decode instruction: valid, destination, result latency
//   src_{a,b}_D/_en_D   decode source indices and their read enables
//   hilo_access_D       decode instruction touches HI/LO
//   stall_in[STAGES:0]  external stall, bit 0 = decode, bit k = stage k
//   flush_in[STAGES-1:0] flush, bit k-1 = stage k
//   md_start_E          stage-1 instruction launches multiply/divide
//   fwd_{a,b}_D         0 = register file, k = forward from stage k (combinational)
//   stall_D             decode hazard stall (combinational)
//   md_busy             multiply/divide in progress
//   valid_mask          per-stage entry valid, bit k-1 = stage k
module hazard_scoreboard #(
  parameter int unsigned REG_BITS = 5,
  parameter int unsigned STAGES   = 3,
  parameter int unsigned LAT_BITS = 2,
  parameter int unsigned MD_LAT   = 32,
  parameter int unsigned FW       = $clog2(STAGES + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid_D,
  input  logic [REG_BITS-1:0] issue_dest_D,
  input  logic [LAT_BITS-1:0] issue_lat_D,
  input  logic [REG_BITS-1:0] src_a_D,
  input  logic [REG_BITS-1:0] src_b_D,
  input  logic                src_a_en_D,
  input  logic                src_b_en_D,
  input  logic                hilo_access_D,
  input  logic [STAGES:0]     stall_in,
  input  logic [STAGES-1:0]   flush_in,
  input  logic                md_start_E,
  output logic [FW-1:0]       fwd_a_D,
  output logic [FW-1:0]       fwd_b_D,
  output logic                stall_D,
  output logic                md_busy,
  output logic [STAGES-1:0]   valid_mask
);

  localparam int unsigned MD_BITS = $clog2(MD_LAT + 1);

  // Entry index i holds stage i+1.
  logic [STAGES-1:0]                valid_q, valid_d;
  logic [STAGES-1:0][REG_BITS-1:0]  dest_q, dest_d;
  logic [STAGES-1:0][LAT_BITS-1:0]  lat_q, lat_d;
  logic [MD_BITS-1:0]               md_cnt_q, md_cnt_d;

  logic hazard_a, hazard_b;

  // Returns {hazard, fwd}: youngest matching entry wins; it forwards only if
  // its stage number is past the stage at which the result is produced.
  function automatic logic [FW:0] fwd_lookup(
    input logic [REG_BITS-1:0]               src,
    input logic                              en,
    input logic [STAGES-1:0]                 vld,
    input logic [STAGES-1:0][REG_BITS-1:0]   dests,
    input logic [STAGES-1:0][LAT_BITS-1:0]   lats
  );
    logic          found;
    logic [FW:0]   res;
    found = 1'b0;
    res   = '0;
    if (en && (src != '0)) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        if (!found && vld[i] && (dests[i] == src)) begin
          found = 1'b1;
          if ((i + 32'd1) > 32'(lats[i])) begin
            res[FW-1:0] = FW'(i + 32'd1);
          end else begin
            res[FW] = 1'b1;
          end
        end
      end
    end
    return res;
  endfunction

  // Decode-side forward selects and stall.
  always_comb begin
    {hazard_a, fwd_a_D} = fwd_lookup(src_a_D, src_a_en_D, valid_q, dest_q, lat_q);
    {hazard_b, fwd_b_D} = fwd_lookup(src_b_D, src_b_en_D, valid_q, dest_q, lat_q);
    md_busy             = (md_cnt_q != '0);
    stall_D             = issue_valid_D & (hazard_a | hazard_b | (hilo_access_D & md_busy));
  end

  // Pipeline advance: flush beats stall, stall holds, otherwise shift in.
  always_comb begin
    valid_d  = valid_q;
    dest_d   = dest_q;
    lat_d    = lat_q;
    md_cnt_d = md_cnt_q;

    if (flush_in[0]) begin
      valid_d[0] = 1'b0;
    end else if (!stall_in[1]) begin
      // A stalled decode leaves a bubble; index 0 is never tracked.
      valid_d[0] = issue_valid_D & ~stall_in[0] & ~stall_D & (issue_dest_D != '0);
      dest_d[0]  = issue_dest_D;
      lat_d[0]   = issue_lat_D;
    end

    for (int unsigned i = 1; i < STAGES; i++) begin
      if (flush_in[i]) begin
        valid_d[i] = 1'b0;
      end else if (!stall_in[i+1]) begin
        valid_d[i] = valid_q[i-1];
        dest_d[i]  = dest_q[i-1];
        lat_d[i]   = lat_q[i-1];
      end
    end

    // Busy countdown keeps running through stalls; a restart reloads.
    if (md_start_E && !flush_in[0] && !stall_in[1]) begin
      md_cnt_d = MD_BITS'(MD_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MD_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      dest_q   <= '0;
      lat_q    <= '0;
      md_cnt_q <= '0;
    end else begin
      valid_q  <= valid_d;
      dest_q   <= dest_d;
      lat_q    <= lat_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  assign valid_mask = valid_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
`timescale 1ns/1ps
module tb_hazard_scoreboard;

  localparam int S   = 3;
  localparam int SP1 = S + 1;
  localparam int MDL = 4;
  localparam int RB  = 5;
  localparam int LB  = 2;
  localparam int FWB = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid_D;
  logic [RB-1:0] issue_dest_D;
  logic [LB-1:0] issue_lat_D;
  logic [RB-1:0] src_a_D, src_b_D;
  logic          src_a_en_D, src_b_en_D, hilo_access_D;
  logic [S:0]    stall_in;
  logic [S-1:0]  flush_in;
  logic          md_start_E;
  logic [FWB-1:0] fwd_a_D, fwd_b_D;
  logic          stall_D, md_busy;
  logic [S-1:0]  valid_mask;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .REG_BITS(RB), .STAGES(S), .LAT_BITS(LB), .MD_LAT(MDL)
  ) dut (
    .clk(clk), .reset(reset),
    .issue_valid_D(issue_valid_D), .issue_dest_D(issue_dest_D), .issue_lat_D(issue_lat_D),
    .src_a_D(src_a_D), .src_b_D(src_b_D), .src_a_en_D(src_a_en_D), .src_b_en_D(src_b_en_D),
    .hilo_access_D(hilo_access_D), .stall_in(stall_in), .flush_in(flush_in),
    .md_start_E(md_start_E), .fwd_a_D(fwd_a_D), .fwd_b_D(fwd_b_D), .stall_D(stall_D),
    .md_busy(md_busy), .valid_mask(valid_mask)
  );

  typedef struct {
    bit rst; bit iv; int idest; int ilat;
    int sa; bit sae; int sb; bit sbe; bit hilo;
    int stl; int fl; bit mds;
    int e_fa; int e_fb; bit e_st; bit e_busy; int e_vm;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: one record per stage (index k-1 = stage k) plus a busy countdown.
  bit m_v[S];
  int m_d[S];
  int m_l[S];
  int m_cnt;
  int x_fa, x_fb, x_vm;
  bit x_st, x_busy;

  task automatic add(input bit rst, input bit iv, input int idest, input int ilat,
                     input int sa, input bit sae, input int sb, input bit sbe, input bit hilo,
                     input int stl, input int fl, input bit mds,
                     input int e_fa, input int e_fb, input bit e_st, input bit e_busy,
                     input int e_vm);
    vec_t v;
    v.rst = rst; v.iv = iv; v.idest = idest; v.ilat = ilat;
    v.sa = sa; v.sae = sae; v.sb = sb; v.sbe = sbe; v.hilo = hilo;
    v.stl = stl; v.fl = fl; v.mds = mds;
    v.e_fa = e_fa; v.e_fb = e_fb; v.e_st = e_st; v.e_busy = e_busy; v.e_vm = e_vm;
    tbl.push_back(v);
  endtask

  task automatic lookup(input int src, input bit en, output int f, output bit h);
    bit found;
    f = 0; h = 1'b0; found = 1'b0;
    if (en && src != 0) begin
      for (int k = 1; k <= S; k++) begin
        if (!found && m_v[k-1] && m_d[k-1] == src) begin
          found = 1'b1;
          if (k > m_l[k-1]) f = k;
          else h = 1'b1;
        end
      end
    end
  endtask

  task automatic model_eval();
    bit ha, hb;
    lookup(int'(src_a_D), src_a_en_D, x_fa, ha);
    lookup(int'(src_b_D), src_b_en_D, x_fb, hb);
    x_busy = (m_cnt > 0);
    x_st   = issue_valid_D && (ha || hb || (hilo_access_D && x_busy));
    x_vm   = 0;
    for (int k = 0; k < S; k++) if (m_v[k]) x_vm += (1 << k);
  endtask

  task automatic model_step();
    bit nv[S];
    int nd[S];
    int nl[S];
    if (reset) begin
      for (int k = 0; k < S; k++) begin m_v[k] = 1'b0; m_d[k] = 0; m_l[k] = 0; end
      m_cnt = 0;
    end else begin
      for (int k = 0; k < S; k++) begin nv[k] = m_v[k]; nd[k] = m_d[k]; nl[k] = m_l[k]; end
      if (flush_in[0]) nv[0] = 1'b0;
      else if (!stall_in[1]) begin
        nv[0] = issue_valid_D && !stall_in[0] && !x_st && (issue_dest_D != 0);
        nd[0] = int'(issue_dest_D);
        nl[0] = int'(issue_lat_D);
      end
      for (int k = 1; k < S; k++) begin
        if (flush_in[k]) nv[k] = 1'b0;
        else if (!stall_in[k+1]) begin nv[k] = m_v[k-1]; nd[k] = m_d[k-1]; nl[k] = m_l[k-1]; end
      end
      for (int k = 0; k < S; k++) begin m_v[k] = nv[k]; m_d[k] = nd[k]; m_l[k] = nl[k]; end
      if (md_start_E && !flush_in[0] && !stall_in[1]) m_cnt = MDL;
      else if (m_cnt > 0) m_cnt = m_cnt - 1;
    end
  endtask

  task automatic drive(input vec_t v);
    reset         = v.rst;
    issue_valid_D = v.iv;
    issue_dest_D  = RB'(v.idest);
    issue_lat_D   = LB'(v.ilat);
    src_a_D       = RB'(v.sa);
    src_a_en_D    = v.sae;
    src_b_D       = RB'(v.sb);
    src_b_en_D    = v.sbe;
    hilo_access_D = v.hilo;
    stall_in      = SP1'(v.stl);
    flush_in      = S'(v.fl);
    md_start_E    = v.mds;
  endtask

  task automatic check(input string nm, input int fa, input int fb, input bit st,
                       input bit busy, input int vm);
    n_vec++;
    if (fwd_a_D !== FWB'(fa) || fwd_b_D !== FWB'(fb) || stall_D !== st ||
        md_busy !== busy || valid_mask !== S'(vm)) begin
      n_err++;
      $display("FAIL %s: got fa=%0d fb=%0d st=%b busy=%b vm=%b, expected fa=%0d fb=%0d st=%b busy=%b vm=%b",
               nm, fwd_a_D, fwd_b_D, stall_D, md_busy, valid_mask,
               fa, fb, st, busy, S'(vm));
    end
  endtask

  // One clock: drive at negedge, compare mid-cycle, advance model at posedge.
  task automatic run_cycle(input string nm, input vec_t v, input bit use_tbl);
    drive(v);
    #2;
    model_eval();
    if (use_tbl) check(nm, v.e_fa, v.e_fb, v.e_st, v.e_busy, v.e_vm);
    else         check(nm, x_fa, x_fb, x_st, x_busy, x_vm);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t idle, rv;
    int   busy_cycles, lvl;

    idle = '{default: 0};
    drive(idle);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); model_step();
    end
    @(negedge clk);

    //   rst iv dst lat  sa e sb e hl  stl fl md   fa fb st bz vm
    add(0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 3'b000); // reset state
    // ALU r5 then reader
    add(0, 1, 5, 1,   0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 3'b000);
    add(0, 1, 0, 0,   5, 1, 0, 0, 0,  0, 0, 0,   0, 0, 1, 0, 3'b001);
    add(0, 1, 0, 0,   5, 1, 0, 0, 0,  0, 0, 0,   2, 0, 0, 0, 3'b010);
    add(0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 3'b100);
    // load r7 then reader
    add(0, 1, 7, 2,   0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 3'b000);
    add(0, 1, 0, 0,   7, 1, 0, 0, 0,  0, 0, 0,   0, 0, 1, 0, 3'b001);
    add(0, 1, 0, 0,   7, 1, 0, 0, 0,  0, 0, 0,   0, 0, 1, 0, 3'b010);
    add(0, 1, 0, 0,   7, 1, 0, 0, 0,  0, 0, 0,   3, 0, 0, 0, 3'b100);
    // r3 in stages 2 and 3, youngest wins; r0 source
    add(0, 1, 3, 1,   0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 3'b000);
    add(0, 1, 3, 1,   0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 3'b001);
    add(0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 3'b011);
    add(0, 1, 0, 0,   0, 0, 3, 1, 0,  0, 0, 0,   0, 2, 0, 0, 3'b110);
    add(0, 1, 0, 0,   0, 0, 0, 1, 0,  0, 0, 0,   0, 0, 0, 0, 3'b100);
    // r9 flushed as it enters stage 1
    add(0, 1, 9, 1,   0, 0, 0, 0, 0,  0, 1, 0,   0, 0, 0, 0, 3'b000);
    add(0, 1, 0, 0,   9, 1, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 3'b000);
    // multiply/divide busy, hilo stall, restart at count 2
    add(0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 1,   0, 0, 0, 0, 3'b000);
    add(0, 1, 0, 0,   0, 0, 0, 0, 1,  0, 0, 0,   0, 0, 1, 1, 3'b000);
    add(0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 1, 3'b000);
    add(0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 1,   0, 0, 0, 1, 3'b000);
    for (int i = 0; i < 4; i++)
      add(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 1, 3'b000);
    add(0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 3'b000);
    add(0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 1,   0, 0, 0, 0, 3'b000);
    add(0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 1, 3'b000);
    add(0, 0, 0, 0,   0, 0, 0, 0, 1,  0, 0, 0,   0, 0, 0, 1, 3'b000);
    add(0, 1, 0, 0,   0, 0, 0, 0, 1,  0, 0, 0,   0, 0, 1, 1, 3'b000);
    add(0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 1, 3'b000);
    add(0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 3'b000);
    // start dropped under flush, then under stage-1 stall
    add(0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 1, 1,   0, 0, 0, 0, 3'b000);
    add(0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 3'b000);
    add(0, 0, 0, 0,   0, 0, 0, 0, 0,  3, 0, 1,   0, 0, 0, 0, 3'b000);
    add(0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 3'b000);
    // fill all stages, reset mid-operation
    add(0, 1, 1, 1,   0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 3'b000);
    add(0, 1, 2, 1,   0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 3'b001);
    add(0, 1, 3, 1,   0, 0, 0, 0, 0,  0, 0, 1,   0, 0, 0, 0, 3'b011);
    add(1, 1, 0, 0,   1, 1, 2, 1, 0,  0, 0, 0,   3, 2, 0, 1, 3'b111);
    add(0, 1, 0, 0,   1, 1, 2, 1, 0,  0, 0, 0,   0, 0, 0, 0, 3'b000);
    // stage-1 stall holds the entry; flush beats stall
    add(0, 1, 4, 1,   0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 3'b000);
    add(0, 1, 0, 0,   4, 1, 0, 0, 0,  3, 0, 0,   0, 0, 1, 0, 3'b001);
    add(0, 1, 0, 0,   4, 1, 0, 0, 0,  0, 0, 0,   0, 0, 1, 0, 3'b011);
    add(0, 1, 0, 0,   4, 1, 0, 0, 0,  0, 0, 0,   2, 0, 0, 0, 3'b110);
    add(0, 1, 6, 1,   0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 3'b100);
    add(0, 0, 0, 0,   0, 0, 0, 0, 0,  3, 1, 0,   0, 0, 0, 0, 3'b001);
    add(0, 1, 0, 0,   6, 1, 0, 0, 0,  0, 0, 0,   2, 0, 0, 0, 3'b010);

    foreach (tbl[i]) run_cycle($sformatf("vec%0d", i), tbl[i], 1'b1);

    // Busy window length after a single start pulse.
    rv = idle; rv.mds = 1'b1;
    run_cycle("md_pulse", rv, 1'b0);
    busy_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (md_busy === 1'b1) busy_cycles++;
      run_cycle($sformatf("md_tail%0d", i), idle, 1'b0);
    end
    n_vec++;
    if (busy_cycles != MDL) begin
      n_err++;
      $display("FAIL md_busy_len: got %0d busy cycles, expected %0d", busy_cycles, MDL);
    end

    // Randomised traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      rv       = idle;
      rv.rst   = ($urandom_range(0, 99) == 0);
      rv.iv    = ($urandom_range(0, 3) != 0);
      rv.idest = $urandom_range(0, 7);
      rv.ilat  = $urandom_range(0, 3);
      rv.sa    = $urandom_range(0, 7);
      rv.sae   = ($urandom_range(0, 3) != 0);
      rv.sb    = $urandom_range(0, 7);
      rv.sbe   = ($urandom_range(0, 3) != 0);
      rv.hilo  = ($urandom_range(0, 3) == 0);
      rv.mds   = ($urandom_range(0, 7) == 0);
      lvl      = $urandom_range(0, 9);
      rv.stl   = (lvl < 6) ? 0 : ((1 << (lvl - 5)) - 1);
      for (int b = 0; b < S; b++) if ($urandom_range(0, 7) == 0) rv.fl += (1 << b);
      run_cycle($sformatf("rand%0d", n), rv, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
